seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the pattern register width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port start_valid, input, 1, a burst request.
REQ-005 The block SHALL have port start_ready, output, 1, asserted when the block accepts a request.
REQ-006 The block SHALL have port pattern, input, WIDTH, the data bits, sent MSB-first from bit len.
REQ-007 The block SHALL have port len, input, $clog2(WIDTH); the number of data bits is len+1.
REQ-008 The block SHALL have port reps, input, 4; the number of frames is reps+1.
REQ-009 The block SHALL have port abort, input, 1, which terminates a burst.
REQ-010 The block SHALL have port dout, output, 1, the serial bit.
REQ-011 The block SHALL have port dout_valid, output, 1, which qualifies dout.
REQ-012 The block SHALL have port frame_start, output, 1, high on the first preamble bit of each frame.
REQ-013 The block SHALL have port done, output, 1, a one-cycle pulse when a burst completes normally.

Function
REQ-014 Handshake: a request SHALL be accepted on the rising edge where start_valid && start_ready; start_ready SHALL be 1 only in IDLE.
REQ-015 On acceptance, pattern, len and reps SHALL be latched; input changes during a burst SHALL have no effect.
REQ-016 start_valid while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-017 The FSM states SHALL be IDLE, PRE1, PRE0, DATA, GAP and DONE, with Moore outputs decoded from state and registered counters only.
REQ-018 IDLE SHALL drive dout=0, dout_valid=0 and start_ready=1, and SHALL go to PRE1 on acceptance.
REQ-019 PRE1 SHALL drive dout=1, dout_valid=1 and frame_start=1, and SHALL go to PRE0.
REQ-020 PRE0 SHALL drive dout=0 and dout_valid=1, and SHALL go to DATA with bit index=len.
REQ-021 DATA SHALL drive dout=pattern_latched[index] and dout_valid=1, and SHALL decrement the index each cycle.
REQ-022 When the index is 0 in DATA, the next state SHALL be DONE if the frame counter is 0; otherwise the frame counter SHALL decrement, the index SHALL reload to len, and the next state SHALL be GAP.
REQ-023 GAP SHALL drive dout=0 and dout_valid=0 for exactly one cycle, then go to PRE1.
REQ-024 DONE SHALL drive done=1 and dout_valid=0 for one cycle, then go to IDLE.
REQ-025 Latency: the first PRE1 cycle SHALL be the cycle immediately after the acceptance edge.
REQ-026 Burst length SHALL be (reps+1)*(len+3)+reps cycles from the first PRE1 up to, but not including, DONE.
REQ-027 Boundary: len=0 SHALL send one data bit; reps=15 SHALL send 16 frames with no counter wrap.
REQ-028 Abort in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and dout_valid=0 from that cycle.
REQ-029 Abort in IDLE SHALL have no effect; simultaneous abort and start_valid in IDLE SHALL accept the request.
REQ-030 A new request SHALL be acceptable on the cycle after DONE (IDLE), giving a minimum one-cycle gap between bursts.

Reset
REQ-031 When reset=1 at a rising edge, the block SHALL enter IDLE and clear the counters and latched pattern.
REQ-032 After reset, outputs SHALL be start_ready=1, and dout, dout_valid, frame_start and done all 0.
REQ-033 Reset SHALL take priority over abort and start_valid, including mid-burst.

Structure
REQ-034 Package seq_gen_pkg SHALL hold the seq_state_e enum (IDLE, PRE1, PRE0, DATA, GAP, DONE) and the constants PREAMBLE_HI=1 and PREAMBLE_LO=0.
REQ-035 The design SHALL have one always_ff for the state and counters and one always_comb for the next state and outputs, with a default-first assignment and a default case arc to IDLE.
REQ-036 Sub-module seq_gen_bitcnt SHALL implement the loadable down-counter for the index and frame count, exposing load, dec and zero.

Verification
REQ-037 Scenario: pattern=8'hA5, len=7, reps=0 -> dout_valid for 10 cycles with dout = 1,0,1,0,1,0,0,1,0,1; done on cycle 11; frame_start on cycle 1 only.
REQ-038 Scenario: pattern=8'h03, len=1, reps=2 -> 1,0,1,1, GAP, 1,0,1,1, GAP, 1,0,1,1, then DONE; 14 cycles before done; frame_start 3 times.
REQ-039 Scenario: pattern=8'h01, len=0, reps=0 -> 1,0,1, then done; followed by pattern=8'h00 accepted one cycle after done -> 1,0,0.
REQ-040 Scenario: abort asserted on the 2nd DATA cycle of the 8'hA5 burst -> IDLE next cycle, no done, start_ready=1.
REQ-041 Scenario: reset pulsed mid-GAP -> all outputs reset per REQ-032 on the next cycle, and a subsequent burst starts cleanly.
REQ-042 Scenario: start_valid held high with pattern changing during a burst -> output unaffected, with exactly one new acceptance at the IDLE after DONE.

Source files
------------

// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_pkg
//  Description : Shared types and constants for the seq_gen serial burst
//                generator: FSM state enumeration, preamble bit values and
//                the frame-repeat field width.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_gen_pkg;

    // Burst sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE1 = 3'd1,
        PRE0 = 3'd2,
        DATA = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } seq_state_e;

    // Two-bit frame preamble, sent as HI then LO.
    localparam logic PREAMBLE_HI = 1'b1;
    localparam logic PREAMBLE_LO = 1'b0;

    // Width of the frame-repeat field (reps); frames per burst = reps+1.
    localparam int REPS_W = 4;

endpackage : seq_gen_pkg
`default_nettype wire

// File: rtl/seq_gen_bitcnt.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen_bitcnt
//  Description : Loadable down-counter with zero flag. Used by seq_gen for
//                the data-bit index and for the remaining-frame count.
//  Ports       : clk      - rising-edge clock
//                reset    - synchronous active-high clear
//                load     - load load_val (priority over dec)
//                dec      - decrement by one; saturates at zero
//                load_val - value loaded on load
//                count    - current count
//                zero     - count equals zero
//  Revision    : 1.0  initial release
// ============================================================================
module seq_gen_bitcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            // Saturating: a stray dec at zero must never wrap to all-ones.
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule : seq_gen_bitcnt
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serial burst generator. On an accepted request it emits
//                reps+1 frames, each a 1/0 preamble followed by len+1 data
//                bits of the latched pattern (MSB-first from bit len), with
//                a one-cycle gap between frames and a one-cycle done pulse
//                after the last frame. abort returns to IDLE immediately.
//  Ports       : clk         - rising-edge clock
//                reset       - synchronous active-high reset
//                start_valid - burst request
//                start_ready - high in IDLE (request accepted when both high)
//                pattern     - data bits, WIDTH wide
//                len         - data bits per frame minus one
//                reps        - frames per burst minus one
//                abort       - terminate burst, no done pulse
//                dout        - serial bit
//                dout_valid  - qualifies dout
//                frame_start - high on the first preamble bit of each frame
//                done        - one-cycle pulse on normal completion
//  Revision    : 1.0  initial release
// ============================================================================
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [WIDTH-1:0]         pattern,
    input  logic [$clog2(WIDTH)-1:0] len,
    input  logic [REPS_W-1:0]        reps,
    input  logic                     abort,
    output logic                     dout,
    output logic                     dout_valid,
    output logic                     frame_start,
    output logic                     done
);

    localparam int LEN_W = $clog2(WIDTH);

    // ------------------------------------------------------------------
    // Registered state and request latches
    // ------------------------------------------------------------------
    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [WIDTH-1:0]   r_pattern;
    logic [LEN_W-1:0]   r_len;

    // Combinational controls
    logic               w_accept;
    logic               w_idx_load;
    logic               w_idx_dec;
    logic               w_frm_load;
    logic               w_frm_dec;

    // Counter outputs
    logic [LEN_W-1:0]   w_idx;
    logic               w_idx_zero;
    logic [REPS_W-1:0]  w_frm_count_unused;
    logic               w_frm_zero;

    // ------------------------------------------------------------------
    // Counters: bit index within a frame, and frames still to send after
    // the current one.
    // ------------------------------------------------------------------
    seq_gen_bitcnt #(
        .W (LEN_W)
    ) u_idx_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_idx_load),
        .dec      (w_idx_dec),
        .load_val (r_len),
        .count    (w_idx),
        .zero     (w_idx_zero)
    );

    seq_gen_bitcnt #(
        .W (REPS_W)
    ) u_frm_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_frm_load),
        .dec      (w_frm_dec),
        .load_val (reps),
        .count    (w_frm_count_unused),
        .zero     (w_frm_zero)
    );

    // ------------------------------------------------------------------
    // State register and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_len     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pattern <= pattern;
                r_len     <= len;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, counter control and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_idx_load  = 1'b0;
        w_idx_dec   = 1'b0;
        w_frm_load  = 1'b0;
        w_frm_dec   = 1'b0;
        start_ready = 1'b0;
        dout        = 1'b0;
        dout_valid  = 1'b0;
        frame_start = 1'b0;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                start_ready = 1'b1;
                // abort is ignored here, so a simultaneous request wins.
                if (start_valid) begin
                    w_accept   = 1'b1;
                    w_frm_load = 1'b1;
                    w_next     = PRE1;
                end
            end
            PRE1: begin
                dout        = PREAMBLE_HI;
                dout_valid  = 1'b1;
                frame_start = 1'b1;
                w_next      = PRE0;
            end
            PRE0: begin
                dout       = PREAMBLE_LO;
                dout_valid = 1'b1;
                // r_len was latched at acceptance, so it is stable here.
                w_idx_load = 1'b1;
                w_next     = DATA;
            end
            DATA: begin
                dout       = r_pattern[w_idx];
                dout_valid = 1'b1;
                if (w_idx_zero) begin
                    if (w_frm_zero) begin
                        w_next = DONE;
                    end else begin
                        w_frm_dec  = 1'b1;
                        w_idx_load = 1'b1;
                        w_next     = GAP;
                    end
                end else begin
                    w_idx_dec = 1'b1;
                end
            end
            GAP: begin
                w_next = PRE1;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Abort overrides every arc out of a busy state; counter updates
        // made in the same cycle are harmless because IDLE reloads them.
        if (abort && (r_state != IDLE)) begin
            w_next = IDLE;
        end
    end

endmodule : seq_gen
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen
//  Description : Self-checking bench for seq_gen. A frame-level reference
//                model builds the expected per-cycle output stream for each
//                burst; directed scenarios are followed by randomized bursts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_gen;

    localparam int WIDTH = 8;

    logic       clk;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] pattern;
    logic [2:0] len;
    logic [3:0] reps;
    logic       abort;
    logic       dout;
    logic       dout_valid;
    logic       frame_start;
    logic       done;

    int passed;
    int total;

    seq_gen #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .pattern     (pattern),
        .len         (len),
        .reps        (reps),
        .abort       (abort),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: {dout, dout_valid, frame_start, done, start_ready}
    logic [4:0] outs;
    assign outs = {dout, dout_valid, frame_start, done, start_ready};

    localparam logic [4:0] IDLE_OUTS = 5'b00001;
    localparam logic [4:0] DONE_OUTS = 5'b00010;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b (dout,valid,fstart,done,ready)", tag, obs, exp);
    endtask

    // Issue one request in the current (IDLE) cycle and check the whole burst.
    // kill_kind: 0 none, 1 abort, 2 reset, applied in burst cycle kill_at
    // (cycle 0 = first PRE1). hold keeps start_valid high with junk inputs.
    task automatic burst(input logic [7:0] pat, input logic [2:0] ln,
                         input logic [3:0] rp, input int kill_at,
                         input int kill_kind, input bit hold, input bit abort_req);
        logic [2:0] q[$];   // {dout, dout_valid, frame_start}
        check("idle_before_req", outs, IDLE_OUTS);
        start_valid = 1'b1;
        pattern     = pat;
        len         = ln;
        reps        = rp;
        abort       = abort_req;
        step();
        abort = 1'b0;
        if (!hold) start_valid = 1'b0;

        for (int f = 0; f <= int'(rp); f++) begin
            q.push_back(3'b111);
            q.push_back(3'b010);
            for (int i = int'(ln); i >= 0; i--) q.push_back({pat[i], 2'b10});
            if (f < int'(rp)) q.push_back(3'b000);
        end

        for (int c = 0; c < q.size(); c++) begin
            check("burst_cycle", outs, {q[c], 2'b00});
            if (c == kill_at && kill_kind != 0) begin
                if (kill_kind == 1) abort = 1'b1;
                else                reset = 1'b1;
                step();
                abort       = 1'b0;
                reset       = 1'b0;
                start_valid = 1'b0;
                check(kill_kind == 1 ? "after_abort" : "after_reset", outs, IDLE_OUTS);
                return;
            end
            if (hold) begin
                start_valid = 1'b1;
                pattern     = 8'($urandom);
                len         = 3'($urandom);
                reps        = 4'($urandom);
            end
            step();
        end
        check("done_pulse", outs, DONE_OUTS);
        start_valid = hold;
        step();
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset       = 1'b1;
        start_valid = 1'b0;
        pattern     = '0;
        len         = '0;
        reps        = '0;
        abort       = 1'b0;

        repeat (2) step();
        check("reset_outputs", outs, IDLE_OUTS);
        reset = 1'b0;
        step();
        check("idle_after_reset", outs, IDLE_OUTS);

        // Abort alone in IDLE does nothing.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_idle", outs, IDLE_OUTS);

        // Single 8-bit frame.
        burst(8'hA5, 3'd7, 4'd0, -1, 0, 1'b0, 1'b0);
        // Three 2-bit frames with gaps.
        burst(8'h03, 3'd1, 4'd2, -1, 0, 1'b0, 1'b0);
        // One-bit frames back to back, second accepted right after done.
        burst(8'h01, 3'd0, 4'd0, -1, 0, 1'b0, 1'b0);
        burst(8'h00, 3'd0, 4'd0, -1, 0, 1'b0, 1'b0);
        // Abort on the second DATA cycle.
        burst(8'hA5, 3'd7, 4'd0, 3, 1, 1'b0, 1'b0);
        step();
        check("idle_after_abort", outs, IDLE_OUTS);
        // Reset in the first GAP, then a clean burst.
        burst(8'h03, 3'd1, 4'd2, 4, 2, 1'b0, 1'b0);
        burst(8'h5C, 3'd5, 4'd1, -1, 0, 1'b0, 1'b0);
        // Request with simultaneous abort in IDLE is accepted.
        burst(8'h96, 3'd3, 4'd0, -1, 0, 1'b0, 1'b1);
        // Maximum frame count.
        burst(8'hC3, 3'd2, 4'd15, -1, 0, 1'b0, 1'b0);
        // start_valid held with changing inputs; exactly one re-acceptance.
        burst(8'hE7, 3'd7, 4'd1, -1, 0, 1'b1, 1'b0);
        burst(8'h2B, 3'd4, 4'd0, -1, 0, 1'b0, 1'b0);
        step();
        check("idle_after_hold", outs, IDLE_OUTS);

        // Randomized bursts.
        for (int k = 0; k < 8; k++) begin
            burst(8'($urandom), 3'($urandom), 4'($urandom_range(5, 0)),
                  -1, 0, bit'($urandom_range(1, 0)), 1'b0);
        end
        burst(8'($urandom), 3'($urandom), 4'($urandom_range(3, 0)), -1, 0, 1'b0, 1'b0);
        repeat (2) begin
            step();
            check("idle_final", outs, IDLE_OUTS);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_seq_gen
`default_nettype wire
